// File: rtl/lbr_unit.sv
// lbr_unit: last-branch-record buffer.
// Captures taken branch/jump pairs (from PC, to PC) into a circular store and
// answers RDLBR reads and WRLBR control writes from the decode stage.
//
// Ports:
//   clock, reset      core clock, synchronous active-high reset
//   lbrReq            00 none, 01 read, 10 control write, 11 reserved
//   lbr_index         read select: MSB picks to-PC half, low bits = age (0 newest)
//   lbr_wdata         control word: bit0 enable, bit1 clear, bit2 freeze_on_full
//   br_valid/br_taken resolved control-flow instruction / PC redirected
//   br_from, br_to    branch PC and target PC
//   lbr_rdata         read data, updated one cycle after a read request
//   lbr_rvalid        one-cycle pulse marking lbr_rdata as fresh
//   lbr_count         number of valid records, 0..DEPTH
//   lbr_overflow      sticky: a record was overwritten or dropped
//   lbr_state         00 DISABLED, 01 RECORDING, 10 FROZEN
//   report            message enable for simulation-side monitors; the
//                     synthesizable core itself prints nothing
module lbr_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int INDEX_BITS = 4,
    parameter int CORE       = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            lbrReq,
    input  logic [INDEX_BITS:0]   lbr_index,
    input  logic [DATA_WIDTH-1:0] lbr_wdata,
    input  logic                  br_valid,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_from,
    input  logic [DATA_WIDTH-1:0] br_to,
    output logic [DATA_WIDTH-1:0] lbr_rdata,
    output logic                  lbr_rvalid,
    output logic [INDEX_BITS:0]   lbr_count,
    output logic                  lbr_overflow,
    output logic [1:0]            lbr_state,
    input  logic                  report
);

    localparam logic [1:0] ST_DISABLED  = 2'b00;
    localparam logic [1:0] ST_RECORDING = 2'b01;
    localparam logic [1:0] ST_FROZEN    = 2'b10;

    localparam logic [1:0] REQ_READ = 2'b01;
    localparam logic [1:0] REQ_CTRL = 2'b10;

    localparam logic [INDEX_BITS:0] FULL_COUNT = (INDEX_BITS+1)'(DEPTH);
    localparam logic [INDEX_BITS:0] LAST_FILL  = (INDEX_BITS+1)'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] from_mem [DEPTH];
    logic [DATA_WIDTH-1:0] to_mem   [DEPTH];

    logic [INDEX_BITS-1:0] wptr;
    logic                  freeze_on_full;

    logic                  is_read;
    logic                  is_ctrl;
    logic                  ctrl_clear;
    logic                  ctrl_enable;
    logic                  taken;
    logic                  capture;
    logic                  is_full;
    logic [INDEX_BITS-1:0] age;
    logic [INDEX_BITS-1:0] rd_slot;
    logic                  age_valid;
    logic [DATA_WIDTH-1:0] rd_word;

    // Ignored control-word bits and the report/core-id hooks.
    logic unused_inputs;
    assign unused_inputs = ^{report, lbr_wdata[DATA_WIDTH-1:3], (CORE != 0)};

    assign is_read     = (lbrReq == REQ_READ);
    assign is_ctrl     = (lbrReq == REQ_CTRL);
    assign ctrl_clear  = is_ctrl & lbr_wdata[1];
    assign ctrl_enable = lbr_wdata[0];
    assign taken       = br_valid & br_taken;
    // A clear in the same cycle discards the capture.
    assign capture     = taken & (lbr_state == ST_RECORDING) & ~ctrl_clear;
    assign is_full     = (lbr_count == FULL_COUNT);

    // Age 0 is the slot just behind the write pointer; reads see the
    // pre-capture pointer and contents.
    assign age       = lbr_index[INDEX_BITS-1:0];
    assign rd_slot   = wptr - INDEX_BITS'(1) - age;
    assign age_valid = ({1'b0, age} < lbr_count);
    assign rd_word   = !age_valid       ? '0 :
                       lbr_index[INDEX_BITS] ? to_mem[rd_slot] : from_mem[rd_slot];

    // Record storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clock) begin
        if (capture) begin
            from_mem[wptr] <= br_from;
            to_mem[wptr]   <= br_to;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lbr_rdata      <= '0;
            lbr_rvalid     <= 1'b0;
            lbr_count      <= '0;
            lbr_overflow   <= 1'b0;
            lbr_state      <= ST_DISABLED;
            freeze_on_full <= 1'b0;
            wptr           <= '0;
        end else begin
            lbr_rvalid <= is_read;
            if (is_read) begin
                lbr_rdata <= rd_word;
            end

            if (capture) begin
                wptr <= wptr + INDEX_BITS'(1);
                if (is_full) begin
                    lbr_overflow <= 1'b1;
                end else begin
                    lbr_count <= lbr_count + (INDEX_BITS+1)'(1);
                end
                // Freeze only on the record that fills the buffer, so a
                // re-enable while full wraps instead of re-freezing.
                if (freeze_on_full && (lbr_count == LAST_FILL)) begin
                    lbr_state <= ST_FROZEN;
                end
            end else if (taken && (lbr_state == ST_FROZEN)) begin
                lbr_overflow <= 1'b1;
            end

            // Control write applied last so it overrides capture side effects.
            if (is_ctrl) begin
                lbr_state      <= ctrl_enable ? ST_RECORDING : ST_DISABLED;
                freeze_on_full <= lbr_wdata[2];
                if (ctrl_clear) begin
                    lbr_count    <= '0;
                    wptr         <= '0;
                    lbr_overflow <= 1'b0;
                end
            end
        end
    end

endmodule
